// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_game_ctrl : Pong match sequencer (serve, goal detect, score, pause) |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pong_game_ctrl #(
    parameter logic [9:0] LEFT_GOAL_X     = 10'd20,
    parameter logic [9:0] RIGHT_GOAL_X    = 10'd620,
    parameter logic [3:0] WIN_SCORE       = 4'd7,
    parameter logic [7:0] SERVE_DELAY     = 8'd64,
    parameter logic       FIRST_SERVE_DIR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [9:0] ball_x_pos,
    output logic       ball_hold,
    output logic       ball_center,
    output logic       serve_pulse,
    output logic       serve_dir,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_PAUSE      = 3'd4,
        S_GAME_OVER  = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_start_prev;
    logic       r_pause_prev;
    logic       r_scorer;      // 1 = right player scored
    logic [7:0] r_count;
    logic [3:0] r_left_score;
    logic [3:0] r_right_score;
    logic       r_ball_hold;
    logic       r_ball_center;
    logic       r_serve_pulse;
    logic       r_serve_dir;
    logic       r_game_over;
    logic       r_winner;

    logic       w_start_edge;
    logic       w_pause_edge;
    logic       w_right_goal;
    logic       w_left_goal;
    logic [3:0] w_scored_val;
    logic [3:0] w_new_score;

    assign w_start_edge = start_btn & ~r_start_prev;
    assign w_pause_edge = pause_btn & ~r_pause_prev;
    assign w_right_goal = (ball_x_pos <= LEFT_GOAL_X);
    assign w_left_goal  = (ball_x_pos >= RIGHT_GOAL_X);
    assign w_scored_val = r_scorer ? r_right_score : r_left_score;
    assign w_new_score  = (w_scored_val == 4'hF) ? 4'hF : w_scored_val + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_start_prev  <= 1'b0;
            r_pause_prev  <= 1'b0;
            r_scorer      <= 1'b0;
            r_count       <= 8'd0;
            r_left_score  <= 4'd0;
            r_right_score <= 4'd0;
            r_ball_hold   <= 1'b1;
            r_ball_center <= 1'b1;
            r_serve_pulse <= 1'b0;
            r_serve_dir   <= FIRST_SERVE_DIR;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_start_prev  <= start_btn;
            r_pause_prev  <= pause_btn;
            r_serve_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ball_hold   <= 1'b1;
                    r_ball_center <= 1'b1;
                    if (w_start_edge) begin
                        r_left_score  <= 4'd0;
                        r_right_score <= 4'd0;
                        r_serve_dir   <= FIRST_SERVE_DIR;
                        r_count       <= SERVE_DELAY;
                        r_state       <= S_SERVE_WAIT;
                    end
                end
                S_SERVE_WAIT: begin
                    if (tick) begin
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_serve_pulse <= 1'b1;
                            r_ball_hold   <= 1'b0;
                            r_ball_center <= 1'b0;
                            r_state       <= S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    // Left-side check first so a value satisfying both counts for the right player
                    if (w_right_goal || w_left_goal) begin
                        r_scorer      <= w_right_goal;
                        r_ball_hold   <= 1'b1;
                        r_ball_center <= 1'b0;
                        r_state       <= S_POINT;
                    end else if (w_pause_edge) begin
                        r_ball_hold   <= 1'b1;
                        r_ball_center <= 1'b0;
                        r_state       <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (w_pause_edge) begin
                        r_ball_hold   <= 1'b0;
                        r_ball_center <= 1'b0;
                        r_state       <= S_PLAY;
                    end
                end
                S_POINT: begin
                    if (r_scorer) r_right_score <= w_new_score;
                    else          r_left_score  <= w_new_score;
                    r_ball_hold   <= 1'b1;
                    r_ball_center <= 1'b1;
                    if (w_new_score == WIN_SCORE) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_scorer;
                        r_state     <= S_GAME_OVER;
                    end else begin
                        r_serve_dir <= ~r_scorer;
                        r_count     <= SERVE_DELAY;
                        r_state     <= S_SERVE_WAIT;
                    end
                end
                S_GAME_OVER: begin
                    r_ball_hold   <= 1'b1;
                    r_ball_center <= 1'b1;
                    if (w_start_edge) begin
                        r_left_score  <= 4'd0;
                        r_right_score <= 4'd0;
                        r_game_over   <= 1'b0;
                        r_serve_dir   <= FIRST_SERVE_DIR;
                        r_count       <= SERVE_DELAY;
                        r_state       <= S_SERVE_WAIT;
                    end
                end
                default: begin
                    r_ball_hold   <= 1'b1;
                    r_ball_center <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign ball_hold   = r_ball_hold;
    assign ball_center = r_ball_center;
    assign serve_pulse = r_serve_pulse;
    assign serve_dir   = r_serve_dir;
    assign left_score  = r_left_score;
    assign right_score = r_right_score;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pong_game_ctrl : directed self-checking bench for pong_game_ctrl      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       start_btn;
    logic       pause_btn;
    logic [9:0] ball_x_pos;
    logic       ball_hold;
    logic       ball_center;
    logic       serve_pulse;
    logic       serve_dir;
    logic [3:0] left_score;
    logic [3:0] right_score;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int n_cmp;
    int n_err;
    int exp_l;
    int exp_r;

    pong_game_ctrl #(
        .LEFT_GOAL_X    (10'd20),
        .RIGHT_GOAL_X   (10'd620),
        .WIN_SCORE      (4'd3),
        .SERVE_DELAY    (8'd4),
        .FIRST_SERVE_DIR(1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .ball_x_pos (ball_x_pos),
        .ball_hold  (ball_hold),
        .ball_center(ball_center),
        .serve_pulse(serve_pulse),
        .serve_dir  (serve_dir),
        .left_score (left_score),
        .right_score(right_score),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic serve_now();
        tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        n_cmp++;
        if (serve_pulse !== 1'b1 || state !== 3'd2 || ball_hold !== 1'b0) begin
            n_err++;
            $display("FAIL serve: pulse=%b state=%0d hold=%b, required pulse=1 state=2 hold=0",
                     serve_pulse, state, ball_hold);
        end
        @(negedge clk);
    endtask

    task automatic score_goal(input logic [9:0] x, input logic right_scores);
        ball_x_pos = x;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd3 || ball_hold !== 1'b1 || ball_center !== 1'b0) begin
            n_err++;
            $display("FAIL point_state x=%0d: state=%0d hold=%b center=%b, required 3 1 0",
                     x, state, ball_hold, ball_center);
        end
        ball_x_pos = 10'd320;
        @(negedge clk);
        if (right_scores) exp_r++; else exp_l++;
        n_cmp++;
        if (left_score !== 4'(exp_l) || right_score !== 4'(exp_r)) begin
            n_err++;
            $display("FAIL score x=%0d: %0d:%0d, required %0d:%0d",
                     x, left_score, right_score, exp_l, exp_r);
        end
        if (exp_l < 3 && exp_r < 3) begin
            n_cmp++;
            if (state !== 3'd1 || serve_dir !== ~right_scores || ball_center !== 1'b1) begin
                n_err++;
                $display("FAIL after_point x=%0d: state=%0d dir=%b center=%b, required 1 %b 1",
                         x, state, serve_dir, ball_center, ~right_scores);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (state !== 3'd0 || left_score !== 4'd0 || right_score !== 4'd0 || ball_hold !== 1'b1 ||
            ball_center !== 1'b1 || serve_pulse !== 1'b0 || serve_dir !== 1'b1 ||
            game_over !== 1'b0 || winner !== 1'b0) begin
            n_err++;
            $display("FAIL reset: state=%0d sc=%0d:%0d hold=%b ctr=%b sp=%b dir=%b go=%b win=%b",
                     state, left_score, right_score, ball_hold, ball_center, serve_pulse,
                     serve_dir, game_over, winner);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_serve();
        logic early;
        early = 1'b0;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        n_cmp++;
        if (state !== 3'd1 || ball_hold !== 1'b1 || ball_center !== 1'b1 || serve_dir !== 1'b1) begin
            n_err++;
            $display("FAIL start: state=%0d hold=%b center=%b dir=%b, required 1 1 1 1",
                     state, ball_hold, ball_center, serve_dir);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (9) begin
                @(negedge clk);
                if (serve_pulse !== 1'b0) early = 1'b1;
            end
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (k < 4 && serve_pulse !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_err++;
            $display("FAIL serve_early: pulse seen before 4th tick, required none");
        end
        n_cmp++;
        if (serve_pulse !== 1'b1 || state !== 3'd2 || ball_hold !== 1'b0 ||
            ball_center !== 1'b0 || serve_dir !== 1'b1) begin
            n_err++;
            $display("FAIL serve_release: pulse=%b state=%0d hold=%b center=%b dir=%b, required 1 2 0 0 1",
                     serve_pulse, state, ball_hold, ball_center, serve_dir);
        end
        @(negedge clk);
        n_cmp++;
        if (serve_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL serve_width: pulse=%b on second clk, required 0", serve_pulse);
        end
    endtask

    task automatic test_goals();
        ball_x_pos = 10'd21;
        @(negedge clk);
        ball_x_pos = 10'd619;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL no_goal_edges: state=%0d, required 2", state);
        end
        score_goal(10'd20, 1'b1);
        serve_now();
        score_goal(10'd620, 1'b0);
        serve_now();
    endtask

    task automatic test_pause();
        pause_btn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd4 || ball_hold !== 1'b1 || ball_center !== 1'b0) begin
            n_err++;
            $display("FAIL pause_enter: state=%0d hold=%b center=%b, required 4 1 0",
                     state, ball_hold, ball_center);
        end
        ball_x_pos = 10'd10;
        tick = 1'b1;
        start_btn = 1'b1;
        repeat (5) @(negedge clk);
        pause_btn = 1'b0;
        tick = 1'b0;
        start_btn = 1'b0;
        ball_x_pos = 10'd320;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd4 || left_score !== 4'(exp_l) || right_score !== 4'(exp_r)) begin
            n_err++;
            $display("FAIL pause_hold: state=%0d sc=%0d:%0d, required 4 %0d:%0d",
                     state, left_score, right_score, exp_l, exp_r);
        end
        pause_btn = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0;
        n_cmp++;
        if (state !== 3'd2 || ball_hold !== 1'b0) begin
            n_err++;
            $display("FAIL pause_exit: state=%0d hold=%b, required 2 0", state, ball_hold);
        end
        @(negedge clk);
        pause_btn = 1'b1;
        score_goal(10'd15, 1'b1);
        pause_btn = 1'b0;
        serve_now();
    endtask

    task automatic test_win();
        score_goal(10'd5, 1'b1);
        n_cmp++;
        if (game_over !== 1'b1 || winner !== 1'b1 || state !== 3'd5 ||
            ball_hold !== 1'b1 || ball_center !== 1'b1) begin
            n_err++;
            $display("FAIL win: go=%b win=%b state=%0d hold=%b center=%b, required 1 1 5 1 1",
                     game_over, winner, state, ball_hold, ball_center);
        end
        ball_x_pos = 10'd0;
        repeat (4) @(negedge clk);
        ball_x_pos = 10'd700;
        repeat (4) @(negedge clk);
        ball_x_pos = 10'd320;
        n_cmp++;
        if (left_score !== 4'(exp_l) || right_score !== 4'(exp_r) || state !== 3'd5) begin
            n_err++;
            $display("FAIL win_frozen: sc=%0d:%0d state=%0d, required %0d:%0d 5",
                     left_score, right_score, state, exp_l, exp_r);
        end
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        exp_l = 0;
        exp_r = 0;
        n_cmp++;
        if (left_score !== 4'd0 || right_score !== 4'd0 || game_over !== 1'b0 ||
            serve_dir !== 1'b1 || state !== 3'd1) begin
            n_err++;
            $display("FAIL restart: sc=%0d:%0d go=%b dir=%b state=%0d, required 0:0 0 1 1",
                     left_score, right_score, game_over, serve_dir, state);
        end
    endtask

    task automatic test_reset_mid();
        serve_now();
        score_goal(10'd620, 1'b0);
        serve_now();
        score_goal(10'd1023, 1'b0);
        serve_now();
        score_goal(10'd0, 1'b1);
        serve_now();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'd0 || left_score !== 4'd0 || right_score !== 4'd0 || ball_hold !== 1'b1 ||
            ball_center !== 1'b1 || serve_pulse !== 1'b0 || game_over !== 1'b0 || serve_dir !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: state=%0d sc=%0d:%0d hold=%b center=%b sp=%b go=%b dir=%b",
                     state, left_score, right_score, ball_hold, ball_center, serve_pulse,
                     game_over, serve_dir);
        end
        exp_l = 0;
        exp_r = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_start();
        logic moved;
        moved = 1'b0;
        start_btn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd1) begin
            n_err++;
            $display("FAIL hold_start: state=%0d, required 1", state);
        end
        repeat (49) begin
            @(negedge clk);
            if (state !== 3'd1) moved = 1'b1;
        end
        start_btn = 1'b0;
        n_cmp++;
        if (moved) begin
            n_err++;
            $display("FAIL hold_start_single: state left SERVE_WAIT while held, required stay 1");
        end
        tick = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        tick = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        n_cmp++;
        if (serve_pulse !== 1'b1 || state !== 3'd2) begin
            n_err++;
            $display("FAIL start_in_wait: pulse=%b state=%0d, required 1 2 (counter not reloaded)",
                     serve_pulse, state);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_l      = 0;
        exp_r      = 0;
        reset_n    = 1'b0;
        tick       = 1'b0;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        ball_x_pos = 10'd320;
        test_reset();
        test_serve();
        test_goals();
        test_pause();
        test_win();
        test_reset_mid();
        test_back_to_back_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Match sequencer for the Pong datapath. It freezes and re-centres the ball between points, releases it with a serve pulse and direction, and detects goals from the ball X position. It also keeps both scores, declares the winner, and supports pause. It sits between the button inputs, the ball motion block and the score/VGA overlay logic, all on the system clk.

Parameters:
LEFT_GOAL_X, 10'd20, ball_x_pos at or below this value is a goal against the left player
RIGHT_GOAL_X, 10'd620, ball_x_pos at or above this value is a goal against the right player
WIN_SCORE, 4'd7, score that ends the match (1..15)
SERVE_DELAY, 8'd64, motion ticks spent in SERVE_WAIT before release (1..255)
FIRST_SERVE_DIR, 1'b1, serve direction of the first point (1 = toward right, 0 = toward left)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  single-clk strobe per ball motion step
start_btn  input  1  start/restart button, already synchronised, level
pause_btn  input  1  pause toggle button, already synchronised, level
ball_x_pos  input  10  current ball X from the ball block
ball_hold  output  1  1 = ball block must not update position
ball_center  output  1  1 = ball block loads centre position (320,240)
serve_pulse  output  1  one-clk pulse releasing the ball
serve_dir  output  1  X direction to apply on serve_pulse (1 = +X)
left_score  output  4  left player points
right_score  output  4  right player points
game_over  output  1  match finished
winner  output  1  valid when game_over: 0 = left, 1 = right
state  output  3  FSM state for debug: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, PAUSE=4, GAME_OVER=5

Behaviour:
- Reset (async, immediate): state=IDLE, scores=0, ball_hold=1, ball_center=1, serve_pulse=0, serve_dir=FIRST_SERVE_DIR, game_over=0, winner=0, delay counter=0, button edge registers=0.
- Rising-edge detect on start_btn and pause_btn:
  - Register the previous level.
  - edge = btn & ~prev; one clk wide.
  - A held button produces exactly one edge.
- IDLE:
  - Outputs: hold=1, center=1.
  - On start edge: scores←0, serve_dir←FIRST_SERVE_DIR, counter←SERVE_DELAY, go to SERVE_WAIT.
- SERVE_WAIT:
  - Outputs: hold=1, center=1.
  - The counter decrements on each tick only.
  - On a tick with counter==1:
    - serve_pulse=1 for that same clk (registered, asserted the clk after the tick).
    - Go to PLAY.
    - ball_hold and ball_center drop in the same clk serve_pulse rises.
- PLAY:
  - Outputs: hold=0, center=0.
  - Goal check every clk:
    - ball_x_pos ≤ LEFT_GOAL_X → right scores.
    - else ball_x_pos ≥ RIGHT_GOAL_X → left scores.
    - Left check has priority.
  - A goal registers a scorer flag and goes to POINT.
  - A pause edge in the same clk as a goal is ignored; the goal wins.
  - A pause edge with no goal goes to PAUSE.
- PAUSE:
  - Outputs: hold=1, center=0. Position is preserved.
  - Pause edge → PLAY. Start edge is ignored. Ticks are ignored.
- POINT (exactly 1 clk):
  - Outputs: hold=1, center=0.
  - Increment the scorer's score by 1, saturating at 15.
  - If the new score == WIN_SCORE: game_over←1, winner←scorer, go to GAME_OVER.
  - Otherwise: serve_dir←toward the player who conceded (right scored → 0, left scored → 1), counter←SERVE_DELAY, go to SERVE_WAIT.
- GAME_OVER:
  - Outputs: hold=1, center=1. Scores and winner are frozen.
  - On start edge: scores←0, game_over←0, serve_dir←FIRST_SERVE_DIR, counter←SERVE_DELAY, go to SERVE_WAIT.
- Scores change only in POINT, on start edge (IDLE/GAME_OVER) and on reset.
- Counter is 8 bits. It never underflows: it is reloaded on every entry into SERVE_WAIT.
- Reset mid-match returns to IDLE immediately with all reset values. No point is awarded.
- ball_x_pos is treated as unsigned. Values above RIGHT_GOAL_X, including wrapped 1023, count as a right-side goal unless they are also ≤ LEFT_GOAL_X.

Test Plan:
- Reset, start_btn high 1 clk, SERVE_DELAY=4, tick every 10 clks → SERVE_WAIT. serve_pulse single clk after the 4th tick, serve_dir=1, ball_hold falls in the same clk, state=2.
- PLAY, drive ball_x_pos=20 → 1 clk POINT, right_score=1, state=1, serve_dir=0, ball_center=1. Repeat with ball_x_pos=620 → left_score=1, serve_dir=1.
- Hold start_btn high for 50 clks in IDLE → exactly one transition. The second start edge during SERVE_WAIT has no effect.
- PLAY, pause edge → state=4, ball_hold=1, ball_center=0. Goal X and ticks are ignored. Second pause edge → PLAY. Pause edge coincident with ball_x_pos=15 → POINT, not PAUSE.
- WIN_SCORE=3, right scores 3 times → game_over=1, winner=1, right_score=3, hold=1. Further goal positions do not change scores. Start edge → scores 0, game_over=0, serve_dir=FIRST_SERVE_DIR.
- Assert reset_n low mid-PLAY with scores 2:1 → outputs immediately at reset values, state=0, scores 0:0.
